bias_array: RTL and testbench

- Parametrised successor of the single-column bias adder for the tiny-TPU output path.
- Sits between the systolic array's bottom edge and the activation/writeback stage.
- Holds a per-column bias register file, loaded through a write port, and adds each column's bias to that column's skewed systolic output in fixed point.
- Adds selectable saturation and a row/tile counter that pulses when a full output tile has passed through.

---
 rtl/tpu_pkg.sv | 41 ++++
 rtl/bias_lane.sv | 83 ++++++++
 rtl/bias_array.sv | 129 ++++++++++++
 tb/tb_bias_array.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
// Shared fixed-point definitions for the tiny-TPU output path.
//   DATA_W / FRAC_W : default Q(DATA_W-FRAC_W).FRAC_W data format
//   MAX_POS/MAX_NEG : clamp values at the default width
//   LRELU_SHIFT     : leaky-ReLU slope as a right shift (alpha = 2^-LRELU_SHIFT)
//   sat_add()       : exact signed add with optional clamp to a w-bit range
// -----------------------------------------------------------------------------
package tpu_pkg;

    localparam int DATA_W      = 16;
    localparam int FRAC_W      = 8;
    localparam int LRELU_SHIFT = 2;

    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MAX_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    // Operands arrive sign-extended to 64 bits, so their sum is exact (it is
    // the (w+1)-bit sum carried in a wider container). With sat set, the result
    // is clamped to [-2^(w-1), 2^(w-1)-1]; otherwise the caller keeps the low w
    // bits, which is the wrap-around result. w is a constant at every call site.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int          w,
                                            input logic        sat);
        logic [63:0] sum;
        logic [63:0] max_pos;
        logic [63:0] max_neg;
        sum     = a + b;
        max_pos = (64'd1 << (w - 1)) - 64'd1;
        max_neg = ~max_pos;
        if (sat && ($signed(sum) > $signed(max_pos))) begin
            return max_pos;
        end
        if (sat && ($signed(sum) < $signed(max_neg))) begin
            return max_neg;
        end
        return sum;
    endfunction

endpackage

// File: rtl/bias_lane.sv
// -----------------------------------------------------------------------------
// bias_lane
// One output lane: adds the lane bias to the systolic result, registers it,
// and optionally applies leaky ReLU in a second register stage.
// Optional feature: define BIAS_ARRAY_LEAKY_RELU_EN to add the activation stage
// (latency 2 instead of 1).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   valid_in   lane input valid
//   data_in    W-bit signed systolic result
//   bias       W-bit signed bias for this lane (registered in the parent)
//   data_out   W-bit biased (and optionally activated) result, 0 when invalid
//   valid_out  output valid
// -----------------------------------------------------------------------------
module bias_lane
    import tpu_pkg::*;
#(
    parameter int W   = DATA_W,
    parameter int SAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic [W-1:0] data_in,
    input  logic [W-1:0] bias,
    output logic [W-1:0] data_out,
    output logic         valid_out
);

    logic [W-1:0] sum_w;
    logic [W-1:0] add_q;
    logic         add_v_q;

    // Truncating to W bits after sat_add yields either the clamped value or,
    // with SAT=0, the wrap-around low bits.
    always_comb begin
        sum_w = W'(sat_add({{(64-W){data_in[W-1]}}, data_in},
                           {{(64-W){bias[W-1]}},    bias},
                           W, (SAT != 0)));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_q   <= '0;
            add_v_q <= 1'b0;
        end else if (valid_in) begin
            add_q   <= sum_w;
            add_v_q <= 1'b1;
        end else begin
            add_q   <= '0;
            add_v_q <= 1'b0;
        end
    end

`ifdef BIAS_ARRAY_LEAKY_RELU_EN
    logic [W-1:0] act_q;
    logic         act_v_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q   <= '0;
            act_v_q <= 1'b0;
        end else if (add_v_q) begin
            // Negative values are scaled by alpha via an arithmetic shift,
            // which rounds toward minus infinity.
            act_q   <= add_q[W-1] ? W'($signed(add_q) >>> LRELU_SHIFT) : add_q;
            act_v_q <= 1'b1;
        end else begin
            act_q   <= '0;
            act_v_q <= 1'b0;
        end
    end

    assign data_out  = act_q;
    assign valid_out = act_v_q;
`else
    assign data_out  = add_q;
    assign valid_out = add_v_q;
`endif

endmodule

// File: rtl/bias_array.sv
// -----------------------------------------------------------------------------
// bias_array
// Per-column bias adder between the systolic array and the activation /
// writeback stage. Holds a COLS-entry bias register file, adds each column's
// bias to its systolic output (saturating when SAT=1, wrapping when SAT=0),
// and counts rows leaving the last lane, pulsing tile_done_out per ROWS rows.
// Optional feature: define BIAS_ARRAY_LEAKY_RELU_EN for a leaky-ReLU stage in
// every lane; latency becomes 2 and the row counter follows the final stage.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bias_wr_en      bias write strobe
//   bias_wr_addr    column to write
//   bias_wr_data    signed bias value
//   sys_data_in     COLS lanes of W bits, lane c at [c*W +: W]
//   sys_valid_in    per-lane valid
//   z_data_out      per-lane result, 0 when the lane is not valid
//   z_valid_out     per-lane output valid
//   row_count_out   rows completed in the current tile
//   tile_done_out   one-cycle pulse when the last row of a tile leaves lane COLS-1
// -----------------------------------------------------------------------------
module bias_array
    import tpu_pkg::*;
#(
    parameter int COLS = 4,
    parameter int W    = DATA_W,
    parameter int FRAC = FRAC_W,
    parameter int ROWS = 4,
    parameter int SAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bias_wr_en,
    input  logic [$clog2(COLS)-1:0]   bias_wr_addr,
    input  logic [W-1:0]              bias_wr_data,
    input  logic [COLS*W-1:0]         sys_data_in,
    input  logic [COLS-1:0]           sys_valid_in,
    output logic [COLS*W-1:0]         z_data_out,
    output logic [COLS-1:0]           z_valid_out,
    output logic [$clog2(ROWS)-1:0]   row_count_out,
    output logic                      tile_done_out
);

    localparam int CW = $clog2(ROWS);

    // Elaboration-time parameter sanity checks.
    if ((COLS < 2) || ((COLS & (COLS - 1)) != 0)) begin : g_cols_check
        $error("bias_array: COLS must be a power of two >= 2");
    end
    if (ROWS < 2) begin : g_rows_check
        $error("bias_array: ROWS must be >= 2");
    end
    if ((FRAC < 0) || (FRAC >= W)) begin : g_frac_check
        $error("bias_array: FRAC must lie in [0, W-1]");
    end

    // -------------------------------------------------------------------------
    // Bias register file. Lanes read the registered value, so a write in the
    // same cycle as a valid input is seen only from the next cycle on.
    // -------------------------------------------------------------------------
    logic [W-1:0] bias_q [COLS];

    // NOTE: this small register file is flops, not RAM, and it is cleared on
    // reset because a freshly reset array must add zero bias.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < COLS; c++) begin
                bias_q[c] <= '0;
            end
        end else if (bias_wr_en) begin
            bias_q[bias_wr_addr] <= bias_wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Lanes
    // -------------------------------------------------------------------------
    for (genvar c = 0; c < COLS; c++) begin : g_lane
        bias_lane #(
            .W   (W),
            .SAT (SAT)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .valid_in  (sys_valid_in[c]),
            .data_in   (sys_data_in[c*W +: W]),
            .bias      (bias_q[c]),
            .data_out  (z_data_out[c*W +: W]),
            .valid_out (z_valid_out[c])
        );
    end

    // -------------------------------------------------------------------------
    // Row / tile counter, driven by the final-stage valid of the last lane
    // (the last column to drain in the skewed output).
    // -------------------------------------------------------------------------
    logic [CW-1:0] row_cnt_q;
    logic          tile_done_q;
    logic          last_row;

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        last_row = 1'b0;
        if (row_cnt_q == CW'(ROWS - 1)) begin
            last_row = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt_q   <= '0;
            tile_done_q <= 1'b0;
        end else if (z_valid_out[COLS-1]) begin
            if (last_row) begin
                row_cnt_q   <= '0;
                tile_done_q <= 1'b1;
            end else begin
                row_cnt_q   <= row_cnt_q + CW'(1);
                tile_done_q <= 1'b0;
            end
        end else begin
            tile_done_q <= 1'b0;
        end
    end

    assign row_count_out = row_cnt_q;
    assign tile_done_out = tile_done_q;

endmodule

// File: tb/tb_bias_array.sv
// -----------------------------------------------------------------------------
// tb_bias_array
// Self-checking bench for bias_array. Two instances share all inputs: one with
// saturating add (SAT=1) and one with wrap-around add (SAT=0). A behavioural
// model computes expected lane outputs with integer arithmetic, tracks the bias
// file, the output latency and the row/tile count.
// -----------------------------------------------------------------------------
module tb_bias_array;

    localparam int COLS = 4;
    localparam int W    = 16;
    localparam int ROWS = 4;
    localparam int AW   = 2;
    localparam int CW   = 2;
    localparam int MAXP = 32767;
    localparam int MINN = -32768;
`ifdef BIAS_ARRAY_LEAKY_RELU_EN
    localparam int LAT  = 2;
`else
    localparam int LAT  = 1;
`endif

    logic              clk;
    logic              rst;
    logic              bias_wr_en;
    logic [AW-1:0]     bias_wr_addr;
    logic [W-1:0]      bias_wr_data;
    logic [COLS*W-1:0] sys_data_in;
    logic [COLS-1:0]   sys_valid_in;
    logic [COLS*W-1:0] z_data_out;
    logic [COLS-1:0]   z_valid_out;
    logic [CW-1:0]     row_count_out;
    logic              tile_done_out;
    logic [COLS*W-1:0] zw_data_out;
    logic [COLS-1:0]   zw_valid_out;
    logic [CW-1:0]     zw_row_count_out;
    logic              zw_tile_done_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bias_array #(.COLS(COLS), .W(W), .FRAC(8), .ROWS(ROWS), .SAT(1)) dut (
        .clk(clk), .rst(rst),
        .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
        .sys_data_in(sys_data_in), .sys_valid_in(sys_valid_in),
        .z_data_out(z_data_out), .z_valid_out(z_valid_out),
        .row_count_out(row_count_out), .tile_done_out(tile_done_out)
    );

    bias_array #(.COLS(COLS), .W(W), .FRAC(8), .ROWS(ROWS), .SAT(0)) dut_w (
        .clk(clk), .rst(rst),
        .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
        .sys_data_in(sys_data_in), .sys_valid_in(sys_valid_in),
        .z_data_out(zw_data_out), .z_valid_out(zw_valid_out),
        .row_count_out(zw_row_count_out), .tile_done_out(zw_tile_done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------ model
    int                bias_m [COLS];
    logic [COLS*W-1:0] exp_s, exp_w;
    logic [COLS-1:0]   exp_v;
    logic [COLS*W-1:0] st1_s, st1_w;
    logic [COLS-1:0]   st1_v;
    int                cnt_m;
    logic              done_m;

    function automatic logic [W-1:0] ref_add(input int a, input int b, input bit sat);
        int s;
        s = a + b;
        if (sat) begin
            if (s > MAXP) s = MAXP;
            else if (s < MINN) s = MINN;
        end
        return s[W-1:0];
    endfunction

    // alpha = 0.25, rounding toward minus infinity
    function automatic logic [W-1:0] leaky(input logic [W-1:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = (v - 3) / 4;
        return v[W-1:0];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < COLS; c++) bias_m[c] = 0;
        exp_s = '0; exp_w = '0; exp_v = '0;
        st1_s = '0; st1_w = '0; st1_v = '0;
        cnt_m = 0; done_m = 1'b0;
    endtask

    // Drive one clock cycle of stimulus (called at a falling edge), advance the
    // model and return at the next falling edge.
    task automatic cycle(input logic [COLS-1:0] v, input logic [COLS*W-1:0] d,
                         input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd);
        logic [COLS*W-1:0] ns, nw;
        sys_valid_in = v;  sys_data_in  = d;
        bias_wr_en   = we; bias_wr_addr = wa; bias_wr_data = wd;
        // the counter reacts to the outputs visible before this edge
        if (exp_v[COLS-1]) begin
            done_m = (cnt_m == ROWS - 1);
            cnt_m  = (cnt_m + 1) % ROWS;
        end else begin
            done_m = 1'b0;
        end
        for (int c = 0; c < COLS; c++) begin
            ns[c*W +: W] = v[c] ? ref_add(int'($signed(d[c*W +: W])), bias_m[c], 1'b1) : {W{1'b0}};
            nw[c*W +: W] = v[c] ? ref_add(int'($signed(d[c*W +: W])), bias_m[c], 1'b0) : {W{1'b0}};
        end
`ifdef BIAS_ARRAY_LEAKY_RELU_EN
        for (int c = 0; c < COLS; c++) begin
            exp_s[c*W +: W] = st1_v[c] ? leaky(st1_s[c*W +: W]) : {W{1'b0}};
            exp_w[c*W +: W] = st1_v[c] ? leaky(st1_w[c*W +: W]) : {W{1'b0}};
        end
        exp_v = st1_v;
        st1_s = ns; st1_w = nw; st1_v = v;
`else
        exp_s = ns; exp_w = nw; exp_v = v;
`endif
        if (we) bias_m[wa] = int'($signed(wd));
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        cycle('0, '0, 1'b0, '0, '0);
    endtask

    task automatic settle();
        repeat (LAT - 1) idle();
    endtask

    task automatic write_bias(input logic [AW-1:0] a, input logic [W-1:0] b);
        cycle('0, '0, 1'b1, a, b);
    endtask

    task automatic apply_reset();
        sys_valid_in = '0; sys_data_in = '0; bias_wr_en = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b0;
        bias_wr_en = 1'b0; bias_wr_addr = '0; bias_wr_data = '0;
        sys_valid_in = '0; sys_data_in = '0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        total++; if (z_data_out !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", z_data_out); end
        total++; if (z_valid_out !== '0) begin bad++; $display("FAIL reset_valid got=%b want=0", z_valid_out); end
        total++; if (row_count_out !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", row_count_out); end
        total++; if (tile_done_out !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", tile_done_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [COLS*W-1:0] d;
        logic [COLS*W-1:0] want;
        write_bias(2'd0, 16'h0100);
        write_bias(2'd3, 16'hFF00);
        d = '0; d[0*W +: W] = 16'h0280; d[3*W +: W] = 16'h0080;
        cycle(4'b1001, d, 1'b0, '0, '0);
        settle();
        want = '0;
`ifdef BIAS_ARRAY_LEAKY_RELU_EN
        want[0*W +: W] = 16'h0380; want[3*W +: W] = 16'hFFE0;
`else
        want[0*W +: W] = 16'h0380; want[3*W +: W] = 16'hFF80;
`endif
        total++; if (z_data_out !== want) begin bad++; $display("FAIL basic_data got=%h want=%h", z_data_out, want); end
        total++; if (z_data_out !== exp_s) begin bad++; $display("FAIL basic_model got=%h want=%h", z_data_out, exp_s); end
        total++; if (z_valid_out !== 4'b1001) begin bad++; $display("FAIL basic_valid got=%b want=1001", z_valid_out); end
        idle();
        total++; if (z_valid_out !== '0) begin bad++; $display("FAIL basic_valid_drop got=%b want=0", z_valid_out); end
    endtask

    task automatic test_saturation();
        logic [COLS*W-1:0] d;
        logic [W-1:0] want_s [2];
        logic [W-1:0] want_w [2];
`ifdef BIAS_ARRAY_LEAKY_RELU_EN
        want_s[0] = 16'h7FFF; want_w[0] = 16'hE040;
        want_s[1] = 16'hE000; want_w[1] = 16'h7F00;
`else
        want_s[0] = 16'h7FFF; want_w[0] = 16'h8100;
        want_s[1] = 16'h8000; want_w[1] = 16'h7F00;
`endif
        for (int k = 0; k < 2; k++) begin
            write_bias(2'd1, (k == 0) ? 16'h7F00 : 16'h8100);
            d = '0; d[1*W +: W] = (k == 0) ? 16'h0200 : 16'hFE00;
            cycle(4'b0010, d, 1'b0, '0, '0);
            settle();
            total++; if (z_data_out[1*W +: W] !== want_s[k]) begin bad++; $display("FAIL sat_%0d got=%h want=%h", k, z_data_out[1*W +: W], want_s[k]); end
            total++; if (zw_data_out[1*W +: W] !== want_w[k]) begin bad++; $display("FAIL wrap_%0d got=%h want=%h", k, zw_data_out[1*W +: W], want_w[k]); end
            total++; if (z_data_out !== exp_s) begin bad++; $display("FAIL sat_model_%0d got=%h want=%h", k, z_data_out, exp_s); end
            total++; if (zw_data_out !== exp_w) begin bad++; $display("FAIL wrap_model_%0d got=%h want=%h", k, zw_data_out, exp_w); end
        end
    endtask

    task automatic test_collision();
        logic [COLS*W-1:0] d;
        write_bias(2'd2, 16'h0010);
        d = '0; d[2*W +: W] = 16'h0001;
        cycle(4'b0100, d, 1'b1, 2'd2, 16'h0020);
        settle();
        total++; if (z_data_out[2*W +: W] !== 16'h0011) begin bad++; $display("FAIL collide_old got=%h want=0011", z_data_out[2*W +: W]); end
        cycle(4'b0100, d, 1'b0, '0, '0);
        settle();
        total++; if (z_data_out[2*W +: W] !== 16'h0021) begin bad++; $display("FAIL collide_new got=%h want=0021", z_data_out[2*W +: W]); end
        total++; if (z_valid_out !== 4'b0100) begin bad++; $display("FAIL collide_valid got=%b want=0100", z_valid_out); end
    endtask

    task automatic test_tile();
        logic [CW-1:0] prev;
        int changes [$];
        int done_cnt;
        int done_idx;
        apply_reset();
        prev = row_count_out;
        done_cnt = 0;
        done_idx = -1;
        // gapped rows, then idle long enough for the counter to catch up
        for (int i = 0; i < 8 + LAT + 1; i++) begin
            if ((i < 8) && (i % 2 == 0)) cycle(4'b1000, '0, 1'b0, '0, '0);
            else idle();
            total++; if (row_count_out !== CW'(cnt_m)) begin bad++; $display("FAIL tile_gap_count i=%0d got=%0d want=%0d", i, row_count_out, cnt_m); end
            total++; if (tile_done_out !== done_m) begin bad++; $display("FAIL tile_gap_done i=%0d got=%b want=%b", i, tile_done_out, done_m); end
            if (row_count_out !== prev) changes.push_back(int'(row_count_out));
            prev = row_count_out;
            if (tile_done_out === 1'b1) begin done_cnt++; done_idx = i; end
        end
        total++; if (changes.size() !== 4) begin bad++; $display("FAIL tile_seq_len got=%0d want=4", changes.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                total++; if (changes[k] !== (k + 1) % 4) begin bad++; $display("FAIL tile_seq[%0d] got=%0d want=%0d", k, changes[k], (k + 1) % 4); end
            end
        end
        total++; if (done_idx !== 6 + LAT) begin bad++; $display("FAIL tile_gap_pulse_at got=%0d want=%0d", done_idx, 6 + LAT); end
        // back-to-back tile
        done_idx = -1;
        for (int i = 0; i < 4 + LAT + 1; i++) begin
            if (i < 4) cycle(4'b1000, '0, 1'b0, '0, '0);
            else idle();
            total++; if (tile_done_out !== done_m) begin bad++; $display("FAIL tile_b2b_done i=%0d got=%b want=%b", i, tile_done_out, done_m); end
            if (tile_done_out === 1'b1) begin done_cnt++; done_idx = i; end
        end
        total++; if (done_idx !== 3 + LAT) begin bad++; $display("FAIL tile_b2b_pulse_at got=%0d want=%0d", done_idx, 3 + LAT); end
        total++; if (done_cnt !== 2) begin bad++; $display("FAIL tile_pulse_count got=%0d want=2", done_cnt); end
    endtask

    task automatic test_async_reset();
        logic [COLS*W-1:0] d;
        for (int c = 0; c < COLS; c++) write_bias(AW'(c), 16'h0100 * W'(c + 1));
        cycle(4'b1000, '0, 1'b0, '0, '0);
        cycle(4'b1000, '0, 1'b0, '0, '0);
        settle();
        idle();
        total++; if (row_count_out !== CW'(cnt_m)) begin bad++; $display("FAIL arst_pre_count got=%0d want=%0d", row_count_out, cnt_m); end
        sys_valid_in = '0;
        #2 rst = 1'b1;
        #1;
        total++; if (row_count_out !== '0) begin bad++; $display("FAIL arst_count got=%0d want=0", row_count_out); end
        total++; if (z_valid_out !== '0) begin bad++; $display("FAIL arst_valid got=%b want=0", z_valid_out); end
        total++; if (tile_done_out !== 1'b0) begin bad++; $display("FAIL arst_done got=%b want=0", tile_done_out); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        d = {COLS{16'h1234}};
        cycle('1, d, 1'b0, '0, '0);
        settle();
        total++; if (z_data_out !== d) begin bad++; $display("FAIL arst_bias_cleared got=%h want=%h", z_data_out, d); end
        total++; if (z_data_out !== exp_s) begin bad++; $display("FAIL arst_model got=%h want=%h", z_data_out, exp_s); end
        idle();
    endtask

`ifdef BIAS_ARRAY_LEAKY_RELU_EN
    task automatic test_leaky();
        logic [COLS*W-1:0] d;
        apply_reset();
        d = '0; d[0 +: W] = 16'hFC00;
        cycle(4'b0001, d, 1'b0, '0, '0);
        total++; if (z_valid_out[0] !== 1'b0) begin bad++; $display("FAIL leaky_early got=%b want=0", z_valid_out[0]); end
        idle();
        total++; if (z_data_out[0 +: W] !== 16'hFF00) begin bad++; $display("FAIL leaky_neg got=%h want=ff00", z_data_out[0 +: W]); end
        d[0 +: W] = 16'h0300;
        cycle(4'b0001, d, 1'b0, '0, '0);
        idle();
        total++; if (z_data_out[0 +: W] !== 16'h0300) begin bad++; $display("FAIL leaky_pos got=%h want=0300", z_data_out[0 +: W]); end
    endtask
`endif

    task automatic test_random();
        logic [COLS*W-1:0] d;
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < COLS; c++) d[c*W +: W] = W'($urandom);
            cycle(COLS'($urandom), d, ($urandom_range(0, 3) == 0), AW'($urandom), W'($urandom));
            total++; if (z_data_out !== exp_s) begin bad++; $display("FAIL rand_sat_data i=%0d got=%h want=%h", i, z_data_out, exp_s); end
            total++; if (zw_data_out !== exp_w) begin bad++; $display("FAIL rand_wrap_data i=%0d got=%h want=%h", i, zw_data_out, exp_w); end
            total++; if (z_valid_out !== exp_v) begin bad++; $display("FAIL rand_valid i=%0d got=%b want=%b", i, z_valid_out, exp_v); end
            total++; if (row_count_out !== CW'(cnt_m)) begin bad++; $display("FAIL rand_count i=%0d got=%0d want=%0d", i, row_count_out, cnt_m); end
            total++; if (tile_done_out !== done_m) begin bad++; $display("FAIL rand_done i=%0d got=%b want=%b", i, tile_done_out, done_m); end
            total++; if (zw_tile_done_out !== done_m) begin bad++; $display("FAIL rand_wrap_done i=%0d got=%b want=%b", i, zw_tile_done_out, done_m); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_collision();
        test_tile();
        test_async_reset();
`ifdef BIAS_ARRAY_LEAKY_RELU_EN
        test_leaky();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
